recovery_unit: RTL



---
 rtl/recovery_unit_pkg.sv | 20 ++
 rtl/recovery_unit_rf_replay_writer.sv | 40 ++++
 rtl/recovery_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/recovery_unit_pkg.sv
// Shared fault-tolerance recovery definitions: FSM states, register-count
// derivation and the completed-recovery counter width.
package recovery_unit_pkg;

  localparam int COUNT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_FLUSH,
    ST_RESTORE,
    ST_LOADPC,
    ST_RESUME
  } recovery_state_e;

  function automatic int nregs(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/recovery_unit_rf_replay_writer.sv
// Registered beat-to-write stage: one replayed beat becomes one core
// register-file write a cycle later; x0 writes are dropped but still counted.
module rf_replay_writer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  beat_i,
  input  logic                  clear_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
      count_o <= '0;
    end else begin
      we_o <= beat_i && (addr_i != '0);
      if (beat_i) begin
        waddr_o <= addr_i;
        wdata_o <= data_i;
      end
      // A clear (nested fault) wins over the increment, but the write above still lands.
      if (clear_i) begin
        count_o <= '0;
      end else if (beat_i) begin
        count_o <= count_o + 1'b1;
      end
    end
  end

endmodule

// File: rtl/recovery_unit.sv
// Core-side recovery receiver: follows halt/reset/shift/resume from the
// fault-tolerance controller and restores register file and PC of one core.
module recovery_unit
  import recovery_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   halt_i,
  input  logic                   reset_i,
  input  logic                   shift_i,
  input  logic                   resume_i,
  input  logic [ADDR_WIDTH-1:0]  replay_addr_i,
  input  logic [DATA_WIDTH-1:0]  replay_data_i,
  input  logic [DATA_WIDTH-1:0]  spc_i,
  output logic                   fetch_block_o,
  output logic                   core_rst_o,
  output logic                   rf_we_o,
  output logic [ADDR_WIDTH-1:0]  rf_waddr_o,
  output logic [DATA_WIDTH-1:0]  rf_wdata_o,
  output logic                   pc_we_o,
  output logic [DATA_WIDTH-1:0]  pc_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   incomplete_o,
  output logic [COUNT_WIDTH-1:0] recovery_count_o
);

  localparam int NREGS = nregs(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] LAST_BEAT = (ADDR_WIDTH + 1)'(NREGS - 1);

  recovery_state_e       state, state_next;
  logic                  halt_q;
  logic                  halt_edge;
  logic                  beat;
  logic                  clear;
  logic                  set_incomplete;
  logic [ADDR_WIDTH:0]   beat_count;
  logic [DATA_WIDTH-1:0] pc_q;

  assign halt_edge = halt_i && !halt_q;

  // halt_q tracks halt_i even in reset, so a level already high out of reset is not an edge.
  always_ff @(posedge clk_i) begin
    halt_q <= halt_i;
    if (rst_i) begin
      state            <= ST_IDLE;
      pc_q             <= '0;
      incomplete_o     <= 1'b0;
      recovery_count_o <= '0;
    end else begin
      state <= state_next;
      if (state == ST_LOADPC) pc_q <= spc_i;
      if (state == ST_IDLE && halt_edge) begin
        incomplete_o <= 1'b0;
      end else if (set_incomplete) begin
        incomplete_o <= 1'b1;
      end
      if (state == ST_RESUME && recovery_count_o != '1) begin
        recovery_count_o <= recovery_count_o + 1'b1;
      end
    end
  end

  // shift_i is a valid-only beat: no backpressure, every sampled beat is consumed.
  always_comb begin
    state_next     = state;
    beat           = 1'b0;
    clear          = 1'b0;
    set_incomplete = 1'b0;
    unique case (state)
      ST_IDLE: begin
        clear = 1'b1;
        if (halt_edge) state_next = ST_HALT;
      end
      ST_HALT: begin
        if (reset_i) begin
          state_next = ST_FLUSH;
        end else if (shift_i) begin
          beat       = 1'b1;
          state_next = ST_RESTORE;
        end
      end
      ST_FLUSH: state_next = ST_RESTORE;
      ST_RESTORE: begin
        beat = shift_i;
        if (halt_edge) begin
          clear      = 1'b1;
          state_next = ST_FLUSH;
        end else if (shift_i && beat_count == LAST_BEAT) begin
          state_next = ST_LOADPC;
        end else if (resume_i) begin
          set_incomplete = 1'b1;
          state_next     = ST_LOADPC;
        end
      end
      ST_LOADPC: state_next = ST_RESUME;
      ST_RESUME: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign busy_o        = (state != ST_IDLE);
  assign fetch_block_o = (state != ST_IDLE);
  assign core_rst_o    = (state == ST_FLUSH);
  assign pc_we_o       = (state == ST_LOADPC);
  assign done_o        = (state == ST_RESUME);
  assign pc_o          = pc_we_o ? spc_i : pc_q;

  rf_replay_writer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_writer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .beat_i  (beat),
    .clear_i (clear),
    .addr_i  (replay_addr_i),
    .data_i  (replay_data_i),
    .we_o    (rf_we_o),
    .waddr_o (rf_waddr_o),
    .wdata_o (rf_wdata_o),
    .count_o (beat_count)
  );

endmodule
